// File: rtl/keypad_emulator.sv
// Matrix keypad emulator: presses one hex key on a 4x4 row/column matrix.
// A press goes through a bouncing make, a solid hold, a bouncing break and
// a quiet gap. Column lines follow the scanner's row drive combinationally,
// the way a passive switch would.
//
// Handshake: a request transfers on a rising edge where key_valid and
// key_ready are both high. key_ready is high only while idle. key_valid is
// ignored at every other time and nothing is queued. key_code is sampled
// only on the transfer edge.
module keypad_emulator #(
    parameter int HOLD_CYCLES    = 50000,
    parameter int BOUNCE_CYCLES  = 2000,
    parameter int BOUNCE_TOGGLE  = 250,
    parameter int RELEASE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       busy,
    output logic       press_done,
    output logic [2:0] state_dbg
);

    localparam int MAX_HB = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
    localparam int MAX_P  = (MAX_HB > RELEASE_CYCLES) ? MAX_HB : RELEASE_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;
    localparam int TW     = $clog2(BOUNCE_TOGGLE) + 1;

    // Last count value of each phase. With no bounce phases the bounce value
    // is never compared, so it is simply parked at zero.
    localparam logic [CW-1:0] B_LAST = (BOUNCE_CYCLES > 0) ? CW'(BOUNCE_CYCLES - 1) : '0;
    localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(BOUNCE_TOGGLE - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BOUNCE_IN  = 3'd1,
        S_HOLD       = 3'd2,
        S_BOUNCE_OUT = 3'd3,
        S_GAP        = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tog_q, tog_d;
    logic            contact_q, contact_d;
    logic [1:0]      r_q, r_d;
    logic [1:0]      c_q, c_d;
    logic            press_done_q, press_done_d;

    // Map a hex key to its {row, column} position on the matrix.
    function automatic logic [3:0] key_pos(input logic [3:0] code);
        logic [3:0] pos;
        case (code)
            4'h1: pos = 4'b00_00;
            4'h2: pos = 4'b00_01;
            4'h3: pos = 4'b00_10;
            4'hA: pos = 4'b00_11;
            4'h4: pos = 4'b01_00;
            4'h5: pos = 4'b01_01;
            4'h6: pos = 4'b01_10;
            4'hB: pos = 4'b01_11;
            4'h7: pos = 4'b10_00;
            4'h8: pos = 4'b10_01;
            4'h9: pos = 4'b10_10;
            4'hC: pos = 4'b10_11;
            4'hE: pos = 4'b11_00;
            4'h0: pos = 4'b11_01;
            4'hF: pos = 4'b11_10;
            default: pos = 4'b11_11; // 4'hD
        endcase
        return pos;
    endfunction

    // State, counters, contact and latched key position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tog_q        <= '0;
            contact_q    <= 1'b0;
            r_q          <= 2'd0;
            c_q          <= 2'd0;
            press_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tog_q        <= tog_d;
            contact_q    <= contact_d;
            r_q          <= r_d;
            c_q          <= c_d;
            press_done_q <= press_done_d;
        end
    end

    // Phase sequencing, shared phase counter and bouncing contact model.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        tog_d        = tog_q;
        contact_d    = contact_q;
        r_d          = r_q;
        c_d          = c_q;
        press_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                contact_d = 1'b0;
                if (key_valid) begin
                    {r_d, c_d} = key_pos(key_code);
                    state_d    = (BOUNCE_CYCLES == 0) ? S_HOLD : S_BOUNCE_IN;
                end
            end
            S_BOUNCE_IN:  if (cnt_q == B_LAST) state_d = S_HOLD;
            S_HOLD:       if (cnt_q == H_LAST) state_d = (BOUNCE_CYCLES == 0) ? S_GAP : S_BOUNCE_OUT;
            S_BOUNCE_OUT: if (cnt_q == B_LAST) state_d = S_GAP;
            S_GAP: begin
                if (cnt_q == R_LAST) begin
                    state_d      = S_IDLE;
                    press_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every state entry restarts the phase and sets the contact level
        // the new phase opens with; inside a bounce phase the contact flips
        // every BOUNCE_TOGGLE cycles.
        if (state_d != state_q) begin
            cnt_d = '0;
            tog_d = '0;
            case (state_d)
                S_BOUNCE_IN: contact_d = 1'b1;
                S_HOLD:      contact_d = 1'b1;
                default:     contact_d = 1'b0;
            endcase
        end else if (state_q == S_BOUNCE_IN || state_q == S_BOUNCE_OUT) begin
            if (tog_q == T_LAST) begin
                tog_d     = '0;
                contact_d = ~contact_q;
            end else begin
                tog_d = tog_q + TW'(1);
            end
        end
    end

    // Passive switch: only the latched row can pull the latched column low.
    always_comb begin
        col = 4'hF;
        if (contact_q && !row[r_q]) col[c_q] = 1'b0;
    end

    assign key_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign press_done = press_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: one instance with bounce phases, one without,
// sharing clock, reset and row drive, compared each cycle against a
// timeline model of the press sequence.
module tb_keypad_emulator;

    localparam int H = 8;
    localparam int T = 2;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;

    logic       kv0, kv1;
    logic [3:0] kc0, kc1;
    logic       rdy0, rdy1, busy0, busy1, pd0, pd1;
    logic [3:0] col0, col1;
    logic [2:0] dbg0, dbg1;

    int total = 0;
    int bad   = 0;

    // Reference model: per instance, whether a sequence is running, how many
    // cycles into it we are, which key it presses and the done pulse.
    int         bcy[2] = '{4, 0};
    bit         m_act[2];
    int         m_off[2];
    logic [3:0] m_key[2];
    bit         m_pd[2];

    logic [3:0] keymap[4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                 '{4'h4, 4'h5, 4'h6, 4'hB},
                                 '{4'h7, 4'h8, 4'h9, 4'hC},
                                 '{4'hE, 4'h0, 4'hF, 4'hD}};

    keypad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(4), .BOUNCE_TOGGLE(T), .RELEASE_CYCLES(R)) u_dut_b (
        .clk(clk), .reset(reset), .key_code(kc0), .key_valid(kv0), .key_ready(rdy0),
        .row(row), .col(col0), .busy(busy0), .press_done(pd0), .state_dbg(dbg0)
    );

    keypad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(T), .RELEASE_CYCLES(R)) u_dut_nb (
        .clk(clk), .reset(reset), .key_code(kc1), .key_valid(kv1), .key_ready(rdy1),
        .row(row), .col(col1), .busy(busy1), .press_done(pd1), .state_dbg(dbg1)
    );

    always #5 clk = ~clk;

    // Contact level at a given cycle offset into a press sequence.
    function automatic bit exp_contact(input int off, input int b);
        if (off < b) return ((off / T) % 2) == 0;
        off -= b;
        if (off < H) return 1'b1;
        off -= H;
        if (off < b) return ((off / T) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_col(input int i, input logic [3:0] rw);
        logic [3:0] res;
        res = 4'hF;
        if (m_act[i] && exp_contact(m_off[i], bcy[i])) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (keymap[r][c] == m_key[i] && rw[r] == 1'b0) res = 4'hF ^ (4'b0001 << c);
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_off[i] = 0;
            m_pd[i]  = 1'b0;
        end
    endtask

    task automatic model_tick(input int i, input logic kv, input logic [3:0] kc);
        bit pd_n;
        pd_n = 1'b0;
        if (!m_act[i]) begin
            if (kv) begin
                m_act[i] = 1'b1;
                m_off[i] = 0;
                m_key[i] = kc;
            end
        end else begin
            m_off[i]++;
            if (m_off[i] == 2 * bcy[i] + H + R) begin
                m_act[i] = 1'b0;
                pd_n     = 1'b1;
            end
        end
        m_pd[i] = pd_n;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " colA"},  col0,         exp_col(0, row));
        chk({tag, " rdyA"},  {3'b0, rdy0},  {3'b0, !m_act[0]});
        chk({tag, " busyA"}, {3'b0, busy0}, {3'b0, m_act[0]});
        chk({tag, " pdA"},   {3'b0, pd0},   {3'b0, m_pd[0]});
        chk({tag, " colN"},  col1,         exp_col(1, row));
        chk({tag, " rdyN"},  {3'b0, rdy1},  {3'b0, !m_act[1]});
        chk({tag, " busyN"}, {3'b0, busy1}, {3'b0, m_act[1]});
        chk({tag, " pdN"},   {3'b0, pd1},   {3'b0, m_pd[1]});
    endtask

    // One clock: advance the model on the edge, then check just after it.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) begin
            model_tick(0, kv0, kc0);
            model_tick(1, kv1, kc1);
        end else begin
            model_reset();
        end
        #1;
        check_all(tag);
    endtask

    logic [18:0] col0_tab;

    initial begin
        col0_tab = 19'b111_0011_00000000_1100;
        reset = 1'b0; row = 4'h0;
        kv0 = 1'b0; kc0 = 4'h0; kv1 = 1'b0; kc1 = 4'h0;
        model_reset();

        // Reset values with every row driven low.
        #12;
        check_all("reset");
        chk("reset colA const", col0, 4'hF);
        chk("reset rdyA const", {3'b0, rdy0}, 4'h1);
        #10;
        reset = 1'b1;
        tick("post reset");

        // No-bounce instance: key 5 with row1 driven, then with row1 idle.
        row = 4'b1101; kv1 = 1'b1; kc1 = 4'h5;
        tick("nb accept");
        kv1 = 1'b0;
        chk("nb hold col c0", col1, 4'b1101);
        for (int i = 1; i < H; i++) begin
            tick("nb hold");
            chk("nb hold col", col1, 4'b1101);
        end
        tick("nb gap");
        chk("nb gap col", col1, 4'hF);
        for (int i = 0; i < 5; i++) tick("nb drain");
        row = 4'b1110; kv1 = 1'b1; kc1 = 4'h5;
        for (int i = 0; i < 14; i++) begin
            tick("nb wrong row");
            kv1 = 1'b0;
            chk("nb wrong row col", col1, 4'hF);
        end

        // Bounce instance: key 1 on row0, column 0 follows the bounce profile.
        row = 4'b1110; kv0 = 1'b1; kc0 = 4'h1;
        tick("b accept");
        kv0 = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (i > 0) tick("b seq");
            chk("b col0 profile", {3'b0, col0[0]}, {3'b0, col0_tab[i]});
        end
        tick("b done");
        chk("b press_done", {3'b0, pd0}, 4'h1);
        chk("b ready back", {3'b0, rdy0}, 4'h1);

        // key_valid held with key_code changing: the first key wins.
        kv0 = 1'b1; kc0 = 4'h1; row = 4'b1110;
        for (int i = 0; i < 45; i++) begin
            tick("held valid");
            kc0 = 4'($urandom_range(0, 15));
        end
        kv0 = 1'b0;
        for (int i = 0; i < 22; i++) tick("held drain");

        // Key D while the scanner walks a single low row, also mid-cycle.
        kv0 = 1'b1; kc0 = 4'hD;
        for (int i = 0; i < 24; i++) begin
            row = 4'hF ^ (4'b0001 << (i % 4));
            tick("scan");
            kv0 = 1'b0;
            row = 4'b0111;
            #1 check_all("scan d row");
            row = 4'b1011;
            #1 check_all("scan other row");
        end

        // Reset in the middle of HOLD aborts without a done pulse.
        kv0 = 1'b1; kc0 = 4'h4; kv1 = 1'b1; kc1 = 4'h4; row = 4'b1101;
        tick("abort accept");
        kv0 = 1'b0; kv1 = 1'b0;
        for (int i = 0; i < 6; i++) tick("abort run");
        chk("abort pre col", col0, 4'hE);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("abort async");
        chk("abort col const", col0, 4'hF);
        chk("abort busy const", {3'b0, busy0}, 4'h0);
        for (int i = 0; i < 3; i++) tick("in reset");
        #2 reset = 1'b1;
        kv0 = 1'b1; kc0 = 4'h9;
        tick("first edge accept");
        chk("first edge busy", {3'b0, busy0}, 4'h1);
        kv0 = 1'b0;
        for (int i = 0; i < 22; i++) tick("after abort");

        // Random requests, keys and row drive on both instances.
        for (int i = 0; i < 400; i++) begin
            kv0 = 1'($urandom_range(0, 1));
            kc0 = 4'($urandom_range(0, 15));
            kv1 = 1'($urandom_range(0, 1));
            kc1 = 4'($urandom_range(0, 15));
            row = 4'($urandom_range(0, 15));
            tick("rand");
            if ($urandom_range(0, 3) == 0) begin
                row = 4'($urandom_range(0, 15));
                #1 check_all("rand mid");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
